// File: rtl/mem_region_if.sv
// Two-requester memory bus: A (CPU) and B (DMA/PPU) request/grant plus the shared read return.
interface mem_region_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic              b_we;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rsrc;

  modport master (
    output a_req, a_addr, a_we, a_wdata, b_req, b_addr, b_we, b_wdata,
    input  a_gnt, b_gnt, rdata, rvalid, rsrc
  );

  modport slave (
    input  a_req, a_addr, a_we, a_wdata, b_req, b_addr, b_we, b_wdata,
    output a_gnt, b_gnt, rdata, rvalid, rsrc
  );
endinterface

// File: rtl/mem_region_arb.sv
// Banked memory window shared by two round-robin requesters, with optional ROM mode,
// out-of-window detection and a configurable read pipeline.
module mem_region_arb #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH_LOG2   = 13,
  parameter int unsigned BASE         = 32'hC000,
  parameter int unsigned BANKS        = 1,
  parameter int unsigned READ_LATENCY = 2,
  parameter bit          READ_ONLY    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  mem_region_if.slave bus,
  input  logic       bank_we,
  input  logic [3:0] bank_sel,
  output logic [3:0] bank_cur,
  output logic       oob,
  output logic       ro_viol
);

  localparam int unsigned WIN       = 1 << DEPTH_LOG2;
  localparam int unsigned MEM_DEPTH = WIN * BANKS;
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  // One extra bit so BASE + WIN at the top of the address space does not wrap.
  localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0] HI = (ADDR_W+1)'(BASE + WIN);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              grant_a, grant_b, gnt_any, rd_fire;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              hit;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        bank_q, bank_d;
  logic              oob_q, ro_q;

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] src_q;
  logic [DATA_W-1:0]       dat_q [READ_LATENCY];

  // rr_q = 1 means B has priority on the next conflict.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      grant_a = bus.a_req && (!bus.b_req || !rr_q);
      grant_b = bus.b_req && (!bus.a_req || rr_q);
    end
    gnt_any = grant_a || grant_b;
    rr_d    = rr_q;
    if (bus.a_req && bus.b_req) rr_d = grant_a;

    addr    = grant_b ? bus.b_addr  : bus.a_addr;
    we      = grant_b ? bus.b_we    : bus.a_we;
    wdata   = grant_b ? bus.b_wdata : bus.a_wdata;
    rd_fire = gnt_any && !we;
    hit     = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
    idx     = IDX_W'(32'(bank_q) * WIN + 32'(addr[DEPTH_LOG2-1:0]));

    // BANKS is a power of two, so the modulo keeps the low bank bits; BANKS=1 pins it to 0.
    bank_d = bank_we ? 4'(32'(bank_sel) % BANKS) : bank_q;
  end

  always_ff @(posedge clk) begin
    if (gnt_any && we && hit && !READ_ONLY) mem[idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= 1'b0;
      bank_q <= 4'd0;
      oob_q  <= 1'b0;
      ro_q   <= 1'b0;
      vld_q  <= '0;
      src_q  <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      rr_q     <= rr_d;
      bank_q   <= bank_d;
      oob_q    <= gnt_any && !hit;
      ro_q     <= gnt_any && we && READ_ONLY;
      vld_q[0] <= rd_fire;
      if (rd_fire) begin
        src_q[0] <= grant_b;
        dat_q[0] <= hit ? mem[idx] : '1;
      end
      // Payload only moves with a valid token so the last stage holds rdata between reads.
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          src_q[i] <= src_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign bus.a_gnt  = grant_a;
  assign bus.b_gnt  = grant_b;
  assign bus.rvalid = vld_q[READ_LATENCY-1];
  assign bus.rsrc   = src_q[READ_LATENCY-1];
  assign bus.rdata  = dat_q[READ_LATENCY-1];
  assign bank_cur   = bank_q;
  assign oob        = oob_q;
  assign ro_viol    = ro_q;

endmodule

// File: tb/tb_mem_region_arb.sv
// Directed bench: a 4-bank RAM instance and a single-bank ROM instance share clock and reset.
module tb_mem_region_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       bank_we, ro_bank_we;
  logic [3:0] bank_sel, ro_bank_sel;
  logic [3:0] bank_cur, ro_bank_cur;
  logic       oob, ro_oob;
  logic       ro_viol, ro_ro_viol;
  int         checks = 0;
  int         failures = 0;

  mem_region_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  mem_region_if #(.ADDR_W(16), .DATA_W(8)) bus_ro ();

  mem_region_arb #(.BANKS(4), .READ_LATENCY(2), .READ_ONLY(1'b0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .bank_we(bank_we), .bank_sel(bank_sel),
    .bank_cur(bank_cur), .oob(oob), .ro_viol(ro_viol)
  );

  mem_region_arb #(.BANKS(1), .READ_LATENCY(2), .READ_ONLY(1'b1)) u_ro (
    .clk(clk), .rst(rst), .bus(bus_ro), .bank_we(ro_bank_we), .bank_sel(ro_bank_sel),
    .bank_cur(ro_bank_cur), .oob(ro_oob), .ro_viol(ro_ro_viol)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus_ro.a_req = 0; bus_ro.a_we = 0; bus_ro.a_addr = '0; bus_ro.a_wdata = '0;
    bus_ro.b_req = 0; bus_ro.b_we = 0; bus_ro.b_addr = '0; bus_ro.b_wdata = '0;
    bank_we = 0; bank_sel = '0; ro_bank_we = 0; ro_bank_sel = '0;
  endtask

  task automatic a_access(input logic w, input logic [15:0] ad, input logic [7:0] d);
    bus.a_req = 1; bus.a_we = w; bus.a_addr = ad; bus.a_wdata = d;
  endtask

  task automatic b_access(input logic w, input logic [15:0] ad, input logic [7:0] d);
    bus.b_req = 1; bus.b_we = w; bus.b_addr = ad; bus.b_wdata = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step();
    bus.a_req = 1; bus.b_req = 1;
    #1;
    if (bus.a_gnt !== 1'b0) begin failures++; $display("FAIL rst_a_gnt got=%0h exp=0", bus.a_gnt); end
    checks++;
    if (bus.b_gnt !== 1'b0) begin failures++; $display("FAIL rst_b_gnt got=%0h exp=0", bus.b_gnt); end
    checks++;
    step();
    idle();
    rst = 0;
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%0h exp=0", bus.rvalid); end
    checks++;
    if (bus.rsrc !== 1'b0) begin failures++; $display("FAIL rst_rsrc got=%0h exp=0", bus.rsrc); end
    checks++;
    if (bus.rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%0h exp=00", bus.rdata); end
    checks++;
    if (oob !== 1'b0) begin failures++; $display("FAIL rst_oob got=%0h exp=0", oob); end
    checks++;
    if (ro_ro_viol !== 1'b0) begin failures++; $display("FAIL rst_ro_viol got=%0h exp=0", ro_ro_viol); end
    checks++;
    if (bank_cur !== 4'd0) begin failures++; $display("FAIL rst_bank got=%0h exp=0", bank_cur); end
    checks++;
  endtask

  task automatic test_write_read();
    step();
    a_access(1, 16'hC010, 8'h5A);
    #1;
    if (bus.a_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%0h exp=1", bus.a_gnt); end
    checks++;
    step();
    a_access(0, 16'hC010, 8'h00);
    #1;
    if (bus.a_gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt got=%0h exp=1", bus.a_gnt); end
    checks++;
    step();
    idle();
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rd_early got=%0h exp=0", bus.rvalid); end
    checks++;
    step();
    if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid got=%0h exp=1", bus.rvalid); end
    checks++;
    if (bus.rsrc !== 1'b0) begin failures++; $display("FAIL rd_rsrc got=%0h exp=0", bus.rsrc); end
    checks++;
    if (bus.rdata !== 8'h5A) begin failures++; $display("FAIL rd_data got=%0h exp=5a", bus.rdata); end
    checks++;
    step();
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%0h exp=0", bus.rvalid); end
    checks++;
    if (bus.rdata !== 8'h5A) begin failures++; $display("FAIL rd_hold got=%0h exp=5a", bus.rdata); end
    checks++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      step(); idle(); a_access(1, 16'hC020 + 16'(i), 8'hA0 + 8'(i));
      step(); idle(); b_access(1, 16'hC030 + 16'(i), 8'hB0 + 8'(i));
    end
    for (int k = 0; k < 10; k++) begin
      step();
      idle();
      if (k >= 2) begin
        exp_d = ((k - 2) % 2 == 0) ? 8'hA0 + 8'((k - 2) / 2) : 8'hB0 + 8'((k - 2) / 2);
        if (bus.rvalid !== 1'b1) begin
          failures++; $display("FAIL rr_rvalid k=%0d got=%0h exp=1", k, bus.rvalid);
        end
        checks++;
        if (bus.rsrc !== 1'((k - 2) % 2)) begin
          failures++; $display("FAIL rr_rsrc k=%0d got=%0h exp=%0h", k, bus.rsrc, (k - 2) % 2);
        end
        checks++;
        if (bus.rdata !== exp_d) begin
          failures++; $display("FAIL rr_rdata k=%0d got=%0h exp=%0h", k, bus.rdata, exp_d);
        end
        checks++;
      end
      if (k < 8) begin
        a_access(0, 16'hC020 + 16'((k + 1) / 2), 8'h00);
        b_access(0, 16'hC030 + 16'(k / 2), 8'h00);
        #1;
        if (bus.a_gnt !== 1'(k % 2 == 0) || bus.b_gnt !== 1'(k % 2 == 1)) begin
          failures++;
          $display("FAIL rr_gnt k=%0d got a=%0h b=%0h exp a=%0h b=%0h", k, bus.a_gnt, bus.b_gnt,
                   k % 2 == 0, k % 2 == 1);
        end
        checks++;
      end
    end
    step();
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rr_tail got=%0h exp=0", bus.rvalid); end
    checks++;
  endtask

  task automatic test_banks();
    step(); idle(); a_access(1, 16'hC000, 8'h11);
    step(); idle(); a_access(0, 16'hC000, 8'h00); bank_we = 1; bank_sel = 4'd2;
    step(); idle(); a_access(1, 16'hC000, 8'h22);
    if (bank_cur !== 4'd2) begin failures++; $display("FAIL bank_load got=%0h exp=2", bank_cur); end
    checks++;
    step(); idle(); bank_we = 1; bank_sel = 4'd0;
    if (bus.rdata !== 8'h11 || bus.rvalid !== 1'b1) begin
      failures++; $display("FAIL bank_old got=%0h/%0h exp=11/1", bus.rdata, bus.rvalid);
    end
    checks++;
    step(); idle(); a_access(0, 16'hC000, 8'h00);
    if (bank_cur !== 4'd0) begin failures++; $display("FAIL bank_back got=%0h exp=0", bank_cur); end
    checks++;
    step(); idle(); bank_we = 1; bank_sel = 4'd6;
    step(); idle(); a_access(0, 16'hC000, 8'h00);
    if (bus.rdata !== 8'h11 || bus.rvalid !== 1'b1) begin
      failures++; $display("FAIL bank0_rd got=%0h/%0h exp=11/1", bus.rdata, bus.rvalid);
    end
    checks++;
    if (bank_cur !== 4'd2) begin failures++; $display("FAIL bank_mod got=%0h exp=2", bank_cur); end
    checks++;
    step(); idle();
    step();
    if (bus.rdata !== 8'h22 || bus.rvalid !== 1'b1) begin
      failures++; $display("FAIL bank2_rd got=%0h/%0h exp=22/1", bus.rdata, bus.rvalid);
    end
    checks++;
  endtask

  task automatic test_oob();
    step(); idle(); b_access(1, 16'h8010, 8'h77); bank_we = 1; bank_sel = 4'd0;
    #1;
    if (bus.b_gnt !== 1'b1) begin failures++; $display("FAIL oob_gnt got=%0h exp=1", bus.b_gnt); end
    checks++;
    step(); idle(); b_access(0, 16'h8000, 8'h00);
    if (oob !== 1'b1) begin failures++; $display("FAIL oob_wr got=%0h exp=1", oob); end
    checks++;
    step(); idle();
    if (oob !== 1'b1) begin failures++; $display("FAIL oob_rd got=%0h exp=1", oob); end
    checks++;
    if (bank_cur !== 4'd0) begin failures++; $display("FAIL oob_bank got=%0h exp=0", bank_cur); end
    checks++;
    step(); idle(); a_access(0, 16'hC010, 8'h00);
    if (bus.rvalid !== 1'b1 || bus.rsrc !== 1'b1 || bus.rdata !== 8'hFF) begin
      failures++;
      $display("FAIL oob_open got=%0h/%0h/%0h exp=1/1/ff", bus.rvalid, bus.rsrc, bus.rdata);
    end
    checks++;
    step(); idle();
    if (oob !== 1'b0) begin failures++; $display("FAIL oob_hit got=%0h exp=0", oob); end
    checks++;
    step();
    if (bus.rvalid !== 1'b1 || bus.rsrc !== 1'b0 || bus.rdata !== 8'h5A) begin
      failures++;
      $display("FAIL oob_ram got=%0h/%0h/%0h exp=1/0/5a", bus.rvalid, bus.rsrc, bus.rdata);
    end
    checks++;
  endtask

  task automatic test_read_only();
    step(); idle();
    bus_ro.a_req = 1; bus_ro.a_we = 1; bus_ro.a_addr = 16'hC005; bus_ro.a_wdata = 8'h33;
    #1;
    if (bus_ro.a_gnt !== 1'b1) begin failures++; $display("FAIL ro_gnt got=%0h exp=1", bus_ro.a_gnt); end
    checks++;
    step(); idle();
    bus_ro.a_req = 1; bus_ro.a_we = 0; bus_ro.a_addr = 16'hC005;
    if (ro_ro_viol !== 1'b1) begin failures++; $display("FAIL ro_flag got=%0h exp=1", ro_ro_viol); end
    checks++;
    step(); idle();
    if (ro_ro_viol !== 1'b0) begin failures++; $display("FAIL ro_once got=%0h exp=0", ro_ro_viol); end
    checks++;
    step();
    if (bus_ro.rvalid !== 1'b1 || bus_ro.rdata !== 8'hA7) begin
      failures++; $display("FAIL ro_data got=%0h/%0h exp=1/a7", bus_ro.rvalid, bus_ro.rdata);
    end
    checks++;
  endtask

  task automatic test_reset_midflight();
    step(); idle(); a_access(0, 16'hC020, 8'h00); b_access(0, 16'hC030, 8'h00);
    #1;
    if (bus.a_gnt !== 1'b1) begin failures++; $display("FAIL mid_first got=%0h exp=1", bus.a_gnt); end
    checks++;
    step(); idle(); b_access(0, 16'hC030, 8'h00);
    step(); idle(); a_access(0, 16'hC021, 8'h00);
    step(); idle(); rst = 1; bus.a_req = 1; bus.b_req = 1;
    #1;
    if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
      failures++; $display("FAIL mid_rst_gnt got=%0h/%0h exp=0/0", bus.a_gnt, bus.b_gnt);
    end
    checks++;
    step(); idle(); rst = 0;
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL mid_flush0 got=%0h exp=0", bus.rvalid); end
    checks++;
    step(); idle(); a_access(0, 16'hC022, 8'h00); b_access(0, 16'hC031, 8'h00);
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL mid_flush1 got=%0h exp=0", bus.rvalid); end
    checks++;
    #1;
    if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin
      failures++; $display("FAIL mid_ptr got=%0h/%0h exp=1/0", bus.a_gnt, bus.b_gnt);
    end
    checks++;
    step(); idle();
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL mid_flush2 got=%0h exp=0", bus.rvalid); end
    checks++;
  endtask

  initial begin
    rst = 1;
    idle();
    u_ro.mem[5] = 8'hA7;
    test_reset();
    test_write_read();
    test_round_robin();
    test_banks();
    test_oob();
    test_read_only();
    test_reset_midflight();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_region_arb.md
Name: mem_region_arb

Overview:
Parametrised memory region for the emulator memory map. A single inferred synchronous RAM is shared by two requesters: A is the CPU bus and B is the DMA/PPU fetch. The block adds address-window decode, optional MBC-style bank switching, a read-only (ROM) mode and a configurable read latency, so that ROM, WRAM and HRAM regions all come from one module.

Parameters:
ADDR_W, 16, bus address width in bits
DATA_W, 8, data word width in bits
DEPTH_LOG2, 13, log2 of words per bank (window size)
BASE, 16'hC000, first bus address of the window; must be aligned to 2^DEPTH_LOG2
BANKS, 1, number of banks; power of two, 1..16
READ_LATENCY, 2, cycles from grant to rvalid; legal range 1..4
READ_ONLY, 0, when 1, all writes are dropped and flagged

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
a_req  in  1  requester A access request
a_addr  in  ADDR_W  requester A bus address
a_we  in  1  requester A write (1) or read (0)
a_wdata  in  DATA_W  requester A write data
a_gnt  out  1  requester A granted this cycle (combinational)
b_req  in  1  requester B access request
b_addr  in  ADDR_W  requester B bus address
b_we  in  1  requester B write (1) or read (0)
b_wdata  in  DATA_W  requester B write data
b_gnt  out  1  requester B granted this cycle (combinational)
rdata  out  DATA_W  read data
rvalid  out  1  rdata valid, one-cycle pulse per granted read
rsrc  out  1  owner of rdata: 0 = A, 1 = B
bank_we  in  1  load bank register
bank_sel  in  4  new bank number
bank_cur  out  4  current bank
oob  out  1  pulse: granted access fell outside the window
ro_viol  out  1  pulse: write attempted with READ_ONLY=1

Behaviour:
- Reset values: a_gnt=0, b_gnt=0 while rst is high; rvalid=0, rsrc=0, rdata=0, oob=0, ro_viol=0, bank_cur=0; round-robin pointer favours A. RAM contents are not cleared.
- Reset mid-operation: all in-flight reads are discarded and no rvalid is produced for them.
- Arbitration:
  - At most one grant per cycle.
  - Only one requester active: it is granted.
  - Both active: the requester that did not win the last conflict is granted. The pointer updates only on conflict cycles.
  - A request is held by the requester until its gnt is seen; gnt is the only handshake.
- Decode: hit = (addr >= BASE) && (addr < BASE + 2^DEPTH_LOG2).
  - Physical index = (bank_cur mod BANKS) * 2^DEPTH_LOG2 + addr[DEPTH_LOG2-1:0].
  - With BANKS=1 the bank register is ignored and bank_cur reads 0.
- Bank register:
  - bank_we loads bank_sel mod BANKS at the clock edge.
  - An access granted in the same cycle as bank_we uses the old bank; the new bank applies from the next cycle.
- Write: performed at the edge ending the grant cycle when hit is true and READ_ONLY=0.
  - READ_ONLY=1: write dropped; ro_viol pulses in the following cycle.
- Read:
  - rvalid pulses exactly READ_LATENCY cycles after the grant cycle, carrying the granted requester's ID on rsrc.
  - Back-to-back reads pipeline at one per cycle with no bubbles.
  - rdata holds its last value when rvalid=0.
- Miss (hit=0):
  - Access is still granted, the RAM is untouched, and oob pulses the following cycle.
  - A read miss returns rdata = all ones (open-bus value) with rvalid at the normal latency.
- Read-after-write: a read of the same index granted the cycle after a write returns the new data. A read in the write's own cycle is impossible because there is a single grant per cycle.

Test Plan:
- Reset, then an A write of 8'h5A to 16'hC010, then an A read of 16'hC010 → a_gnt both cycles; rvalid=1, rsrc=0, rdata=8'h5A exactly 2 cycles after the read grant.
- a_req and b_req held high for 4 reads each (distinct addresses) → grants alternate A,B,A,B,A,B,A,B; rvalid on 8 consecutive cycles with rsrc alternating 0/1.
- BANKS=4: write 8'h11 at 16'hC000 in bank 0; bank_we with bank_sel=2; write 8'h22 at 16'hC000; switch back to bank 0 and read → rdata=8'h11. A bank_sel=6 load sets bank_cur=2.
- B read of 16'h8000 (below the window) → oob pulses 1 cycle after the grant; rvalid with rdata=8'hFF at latency; RAM contents unchanged.
- READ_ONLY=1: A write of 8'h33 to 16'hC005, then a read → ro_viol pulses once; the read returns the preloaded value, not 8'h33.
- Three reads issued, with rst asserted one cycle after the last grant → no rvalid after reset. The first post-reset access with both requesters active grants A.
